// File: rtl/reg_status_file.sv
// Architectural register file with rename status (busy/tag), updated from the CDB.
// Reads are combinational, with a same-cycle bypass when the CDB retires the awaited tag.
module reg_status_file #(
  parameter int REG_NUM = 32,
  parameter int TAG_W   = 4,
  parameter int XLEN    = 32
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             rdy_in,
  input  logic             issue_valid,
  input  logic [4:0]       issue_rd,
  input  logic [TAG_W-1:0] issue_tag,
  input  logic [4:0]       rs1_idx,
  input  logic [4:0]       rs2_idx,
  output logic [XLEN-1:0]  rs1_val,
  output logic [XLEN-1:0]  rs2_val,
  output logic             rs1_busy,
  output logic             rs2_busy,
  output logic [TAG_W-1:0] rs1_tag,
  output logic [TAG_W-1:0] rs2_tag,
  input  logic             cdb_active,
  input  logic [TAG_W-1:0] cdb_tag,
  input  logic [XLEN-1:0]  cdb_val,
  input  logic [31:0]      cdb_addr,
  input  logic             predict_fail,
  output logic [31:0]      commit_cnt,
  output logic [31:0]      last_commit_addr
);

  logic [XLEN-1:0]  r_val  [REG_NUM];
  logic             r_busy [REG_NUM];
  logic [TAG_W-1:0] r_tag  [REG_NUM];

  for (genvar g = 0; g < REG_NUM; g++) begin : g_reg
    if (g == 0) begin : g_zero
      assign r_val[g]  = '0;
      assign r_busy[g] = 1'b0;
      assign r_tag[g]  = '0;
    end else begin : g_entry
      logic w_hit;
      logic w_issue;
      assign w_hit   = cdb_active && r_busy[g] && (r_tag[g] == cdb_tag);
      assign w_issue = issue_valid && (issue_rd == 5'(g));

      // Commit first, then issue overrides busy/tag; flush clears both regardless.
      always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
          r_val[g]  <= '0;
          r_busy[g] <= 1'b0;
          r_tag[g]  <= '0;
        end else if (rdy_in) begin
          if (w_hit) begin
            r_val[g]  <= cdb_val;
            r_busy[g] <= 1'b0;
            r_tag[g]  <= '0;
          end
          if (predict_fail) begin
            r_busy[g] <= 1'b0;
            r_tag[g]  <= '0;
          end else if (w_issue) begin
            r_busy[g] <= 1'b1;
            r_tag[g]  <= issue_tag;
          end
        end
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      commit_cnt       <= '0;
      last_commit_addr <= '0;
    end else if (rdy_in && cdb_active) begin
      commit_cnt       <= commit_cnt + 32'd1;
      last_commit_addr <= cdb_addr;
    end
  end

  always_comb begin
    rs1_val  = '0;
    rs1_busy = 1'b0;
    rs1_tag  = '0;
    if (rs1_idx != '0) begin
      if (r_busy[rs1_idx] && cdb_active && (cdb_tag == r_tag[rs1_idx])) begin
        rs1_val = cdb_val;
      end else begin
        rs1_val  = r_val[rs1_idx];
        rs1_busy = r_busy[rs1_idx];
        rs1_tag  = r_tag[rs1_idx];
      end
    end
  end

  always_comb begin
    rs2_val  = '0;
    rs2_busy = 1'b0;
    rs2_tag  = '0;
    if (rs2_idx != '0) begin
      if (r_busy[rs2_idx] && cdb_active && (cdb_tag == r_tag[rs2_idx])) begin
        rs2_val = cdb_val;
      end else begin
        rs2_val  = r_val[rs2_idx];
        rs2_busy = r_busy[rs2_idx];
        rs2_tag  = r_tag[rs2_idx];
      end
    end
  end

endmodule

// File: tb/tb_reg_status_file.sv
// Directed bench for reg_status_file: expectations queued at drive time,
// drained and compared against the DUT shortly after.
module tb_reg_status_file;

  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic        rdy_in;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic [3:0]  issue_tag;
  logic [4:0]  rs1_idx, rs2_idx;
  logic [31:0] rs1_val, rs2_val;
  logic        rs1_busy, rs2_busy;
  logic [3:0]  rs1_tag, rs2_tag;
  logic        cdb_active;
  logic [3:0]  cdb_tag;
  logic [31:0] cdb_val;
  logic [31:0] cdb_addr;
  logic        predict_fail;
  logic [31:0] commit_cnt;
  logic [31:0] last_commit_addr;

  reg_status_file #(.REG_NUM(32), .TAG_W(4), .XLEN(32)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_tag(issue_tag),
    .rs1_idx(rs1_idx), .rs2_idx(rs2_idx),
    .rs1_val(rs1_val), .rs2_val(rs2_val),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .rs1_tag(rs1_tag), .rs2_tag(rs2_tag),
    .cdb_active(cdb_active), .cdb_tag(cdb_tag), .cdb_val(cdb_val), .cdb_addr(cdb_addr),
    .predict_fail(predict_fail),
    .commit_cnt(commit_cnt), .last_commit_addr(last_commit_addr)
  );

  always #5 clk_in = ~clk_in;

  typedef enum {S_V1, S_B1, S_T1, S_V2, S_B2, S_T2, S_CNT, S_ADDR} sig_e;
  typedef struct {
    sig_e        s;
    string       name;
    logic [31:0] exp;
  } item_t;

  item_t q[$];
  int    errors = 0;
  int    checks = 0;

  function automatic logic [31:0] obs_of(sig_e s);
    case (s)
      S_V1:    return rs1_val;
      S_B1:    return 32'(rs1_busy);
      S_T1:    return 32'(rs1_tag);
      S_V2:    return rs2_val;
      S_B2:    return 32'(rs2_busy);
      S_T2:    return 32'(rs2_tag);
      S_CNT:   return commit_cnt;
      default: return last_commit_addr;
    endcase
  endfunction

  task automatic push(sig_e s, string name, logic [31:0] exp);
    item_t it;
    it.s = s; it.name = name; it.exp = exp;
    q.push_back(it);
  endtask

  task automatic exp1(string n, logic [31:0] v, logic b, logic [3:0] t);
    push(S_V1, {n, "_val"}, v);
    push(S_B1, {n, "_busy"}, 32'(b));
    push(S_T1, {n, "_tag"}, 32'(t));
  endtask

  task automatic exp2(string n, logic [31:0] v, logic b, logic [3:0] t);
    push(S_V2, {n, "_val"}, v);
    push(S_B2, {n, "_busy"}, 32'(b));
    push(S_T2, {n, "_tag"}, 32'(t));
  endtask

  task automatic expc(string n, logic [31:0] cnt, logic [31:0] addr);
    push(S_CNT, {n, "_cnt"}, cnt);
    push(S_ADDR, {n, "_addr"}, addr);
  endtask

  task automatic drain();
    item_t       it;
    logic [31:0] o;
    while (q.size() > 0) begin
      it = q.pop_front();
      o = obs_of(it.s);
      checks++;
      assert (o === it.exp) else begin
        errors++;
        $error("FAIL %s: observed=%h expected=%h", it.name, o, it.exp);
      end
    end
  endtask

  task automatic idle();
    rdy_in = 1'b1; issue_valid = 1'b0; issue_rd = '0; issue_tag = '0;
    cdb_active = 1'b0; cdb_tag = '0; cdb_val = '0; cdb_addr = '0; predict_fail = 1'b0;
  endtask

  task automatic iss(logic [4:0] rd, logic [3:0] tg);
    issue_valid = 1'b1; issue_rd = rd; issue_tag = tg;
  endtask

  task automatic cdb(logic [3:0] tg, logic [31:0] v, logic [31:0] a);
    cdb_active = 1'b1; cdb_tag = tg; cdb_val = v; cdb_addr = a;
  endtask

  task automatic cyc();
    @(negedge clk_in);
    idle();
  endtask

  initial begin
    rst_n_in = 1'b0;
    idle();
    rs1_idx = 5'd5; rs2_idx = 5'd7;
    #3;
    exp1("rst_x5", 32'h0, 1'b0, 4'h0);
    exp2("rst_x7", 32'h0, 1'b0, 4'h0);
    expc("rst", 32'h0, 32'h0);
    drain();
    @(negedge clk_in);
    rst_n_in = 1'b1;

    // Rename then commit
    cyc(); iss(5'd5, 4'd3); rs1_idx = 5'd5;
    exp1("pre_issue_x5", 32'h0, 1'b0, 4'h0); #1; drain();
    cyc();
    exp1("renamed_x5", 32'h0, 1'b1, 4'd3); #1; drain();
    cyc(); cdb(4'd3, 32'hDEADBEEF, 32'h0000_1000);
    exp1("bypass_x5", 32'hDEADBEEF, 1'b0, 4'h0); #1; drain();
    cyc();
    exp1("stored_x5", 32'hDEADBEEF, 1'b0, 4'h0);
    expc("commit1", 32'd1, 32'h0000_1000); #1; drain();

    // Re-rename race
    cyc(); iss(5'd7, 4'd2); rs1_idx = 5'd7;
    cyc(); cdb(4'd2, 32'h11, 32'h0000_1004); iss(5'd7, 4'd9);
    exp1("race_bypass_x7", 32'h11, 1'b0, 4'h0); #1; drain();
    cyc();
    exp1("race_x7", 32'h11, 1'b1, 4'd9);
    expc("commit2", 32'd2, 32'h0000_1004); #1; drain();
    cyc(); cdb(4'd9, 32'h22, 32'h0000_1008);
    cyc();
    exp1("race_done_x7", 32'h22, 1'b0, 4'h0);
    expc("commit3", 32'd3, 32'h0000_1008); #1; drain();

    // Stale tag
    cyc(); iss(5'd4, 4'd1);
    cyc(); iss(5'd4, 4'd6);
    cyc(); cdb(4'd1, 32'h55, 32'h0000_2000); rs2_idx = 5'd4;
    exp2("stale_nobypass_x4", 32'h0, 1'b1, 4'd6); #1; drain();
    cyc();
    exp2("stale_x4", 32'h0, 1'b1, 4'd6);
    expc("commit4", 32'd4, 32'h0000_2000); #1; drain();

    // Flush
    cyc(); iss(5'd8, 4'd10);
    cyc(); cdb(4'd10, 32'h88, 32'h0000_3000);
    cyc(); iss(5'd3, 4'd5);
    cyc(); iss(5'd8, 4'd7);
    cyc(); predict_fail = 1'b1; cdb(4'd5, 32'h77, 32'h0000_3004); iss(5'd9, 4'd11);
    cyc(); rs1_idx = 5'd3; rs2_idx = 5'd8;
    exp1("flush_x3", 32'h77, 1'b0, 4'h0);
    exp2("flush_x8", 32'h88, 1'b0, 4'h0);
    expc("commit6", 32'd6, 32'h0000_3004); #1; drain();
    cyc(); rs1_idx = 5'd9; rs2_idx = 5'd4;
    exp1("flush_x9", 32'h0, 1'b0, 4'h0);
    exp2("flush_x4", 32'h0, 1'b0, 4'h0); #1; drain();

    // x0 and pause
    cyc(); iss(5'd0, 4'd12);
    cyc(); iss(5'd10, 4'd13); rs1_idx = 5'd0;
    exp1("x0", 32'h0, 1'b0, 4'h0); #1; drain();
    cyc(); rdy_in = 1'b0; iss(5'd10, 4'd14); cdb(4'd13, 32'h99, 32'h0000_4000); rs1_idx = 5'd10;
    exp1("pause_bypass_x10", 32'h99, 1'b0, 4'h0); #1; drain();
    cyc();
    exp1("pause_x10", 32'h0, 1'b1, 4'd13);
    expc("pause", 32'd6, 32'h0000_3004); #1; drain();

    // Asynchronous reset mid-cycle, held across an active edge
    cyc(); rs2_idx = 5'd5;
    #2 rst_n_in = 1'b0;
    #1;
    exp1("arst_x10", 32'h0, 1'b0, 4'h0);
    exp2("arst_x5", 32'h0, 1'b0, 4'h0);
    expc("arst", 32'h0, 32'h0); drain();
    iss(5'd6, 4'd2); cdb(4'd0, 32'h1, 32'h0000_5000);
    @(posedge clk_in); #1;
    expc("arst_hold", 32'h0, 32'h0); drain();
    @(negedge clk_in); rst_n_in = 1'b1; idle();
    cyc(); iss(5'd5, 4'd1); rs1_idx = 5'd5;
    cyc();
    exp1("post_rst_x5", 32'h0, 1'b1, 4'd1); #1; drain();
    cyc(); rs1_idx = 5'd6;
    exp1("post_rst_x6", 32'h0, 1'b0, 4'h0); #1; drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reg_status_file.md
# reg_status_file

Architectural register file with rename status, sitting at the consumer end of the common data bus (CDB). The commit stage drives the CDB one retired instruction per cycle. Issue marks destination registers as pending on a ROB tag. Each CDB broadcast writes the retired value into every register still waiting on that tag. Decode reads two operands per cycle, with same-cycle CDB bypass; a mispredict flush drops all pending renames.

## Interface
Parameters:
- REG_NUM, 32, number of architectural registers; x0 hard-wired zero
- TAG_W, 4, ROB tag width
- XLEN, 32, data width

Ports:
- clk_in  input  1  system clock; all state updates on posedge
- rst_n_in  input  1  reset; one clock; asynchronous, active-low
- rdy_in  input  1  global ready; low = pause, no state change
- issue_valid  input  1  rename rd onto issue_tag this cycle
- issue_rd  input  5  destination register index
- issue_tag  input  TAG_W  ROB tag of issuing instruction
- rs1_idx, rs2_idx  input  5  operand indices (combinational lookup)
- rs1_val, rs2_val  output  XLEN  operand value (valid when busy=0)
- rs1_busy, rs2_busy  output  1  operand still pending on a tag
- rs1_tag, rs2_tag  output  TAG_W  tag to wait on when busy=1, else 0
- cdb_active  input  1  CDB carries a retiring result this cycle
- cdb_tag  input  TAG_W  tag of retiring instruction
- cdb_val  input  XLEN  result value
- cdb_addr  input  32  PC of retiring instruction
- predict_fail  input  1  flush: clear all pending renames
- commit_cnt  output  32  registered count of accepted CDB commits
- last_commit_addr  output  32  registered cdb_addr of most recent commit

## Operation
- State per register i: val[i] (XLEN), busy[i], tag[i] (TAG_W). Index 0: val=0, busy=0, tag=0 permanently; issue/commit to x0 ignored.
- Commit (cdb_active=1, rdy_in=1): for every i≠0 with busy[i]=1 and tag[i]==cdb_tag: val[i]<=cdb_val, busy[i]<=0, tag[i]<=0. All matches update (no first-match break). commit_cnt<=commit_cnt+1 (wraps 2^32-1→0); last_commit_addr<=cdb_addr. Count/addr update even if no register matches (stores, branches).
- Issue (issue_valid=1, rdy_in=1, predict_fail=0, issue_rd≠0): busy[rd]<=1, tag[rd]<=issue_tag; val[rd] unchanged.
- Issue and commit to same register, same cycle: commit value written to val[rd]; issue wins busy/tag (busy=1, tag=issue_tag).
- Flush (predict_fail=1, rdy_in=1): same-cycle commit still applied to val and counters; then every busy and tag cleared to 0; issue ignored. Values retained.
- Read (combinational): idx=0 → val 0, busy 0, tag 0. Else if busy[idx] && cdb_active && cdb_tag==tag[idx] → val=cdb_val, busy=0, tag=0 (bypass). Else stored val/busy/tag. Reads reflect pre-issue state: same-cycle issue to the read index is not visible until next cycle.
- rdy_in=0: no state change; reads still combinational, bypass still applied.

## Timing
- Reset (rst_n_in low, asynchronous): all val/busy/tag=0, commit_cnt=0, last_commit_addr=0 immediately, held until release; first update on first posedge after release.
- Issue-to-busy: 1 cycle (visible on read the cycle after issue_valid).
- Commit-to-read: 0 cycles via bypass; stored value visible from next cycle.
- Reset mid-operation discards all pending state; no partial updates.
- Commit throughput: 1 per cycle; no backpressure to CDB.

## Test plan
- Reset: drive rst_n_in=0 asynchronously mid-cycle → all rs*_val/busy/tag=0, commit_cnt=0 without clock edge.
- Rename then commit: issue rd=5 tag=3; next cycle rs1_idx=5 → busy=1 tag=3; cdb_active tag=3 val=0xDEADBEEF → same-cycle rs1_val=0xDEADBEEF busy=0; following cycle stored value 0xDEADBEEF, commit_cnt=1.
- Re-rename race: x7 busy tag=2; same cycle cdb tag=2 val=0x11 and issue rd=7 tag=9 → next cycle x7 busy=1 tag=9; after cdb tag=9 val=0x22 → x7=0x22.
- Stale tag: x4 renamed tag=1 then tag=6; cdb tag=1 val=0x55 → x4 stays busy tag=6, commit_cnt increments, last_commit_addr=cdb_addr.
- Flush: x3,x8 busy; predict_fail=1 with cdb tag matching x3 val=0x77 and issue rd=9 → next cycle x3=0x77, x8 old value busy=0, x9 not busy.
- x0 and pause: issue rd=0 → x0 never busy; rdy_in=0 with issue/commit asserted → no state change, commit_cnt unchanged.
